// File: rtl/c2_pkg.sv
// rtl/c2_pkg.sv - shared C2 types and constants for the UART TX scheduler
package c2_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_DONE,
      S_HOLD
   } tx_sched_state_e;

   localparam int TX_REQ_ARBITER = 0;
   localparam int TX_REQ_LOADER  = 1;
   localparam int TX_REQ_DUMPER  = 2;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transceiver handshake bundle
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]   req_valid_i;
   logic [NUM_REQ*8-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [NUM_REQ-1:0]   req_ack_o;
   logic [NUM_REQ-1:0]   req_done_o;
   logic [NUM_REQ-1:0]   grant_o;
   logic [7:0]           tx_data_o;
   logic                 tx_start_o;
   logic                 tx_done_i;
   logic                 timeout_o;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_done_i,
      output req_ack_o, req_done_o, grant_o, tx_data_o, tx_start_o, timeout_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_done_i,
      input  req_ack_o, req_done_o, grant_o, tx_data_o, tx_start_o, timeout_o
   );
endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin find-first over a request vector
module rr_priority_picker #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_idx,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       found
);
   localparam int IDX_W = $clog2(NUM_REQ);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Search starts one past the previous owner so it ends up lowest priority.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_idx) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - frame-locking round-robin owner of the shared UART transmitter
// Optional hold-state watchdog is built when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler
   import c2_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   uart_tx_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   tx_sched_state_e    state, next_state;
   logic [IDX_W-1:0]   owner_idx, last_owner, pick_idx, sel_idx;
   logic [NUM_REQ-1:0] grant_q, pick_grant, done_q;
   logic [7:0]         tx_data_q;
   logic [7:0]         req_bytes [NUM_REQ];
   logic               pick_found, last_q, owner_valid;
   logic               capture, release_frame, done_set;

`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        wd_expire;
   logic        timeout_q;
`endif

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
      assign req_bytes[k] = bus.req_data_i[8*k +: 8];
   end

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req       (bus.req_valid_i),
      .last_idx  (last_owner),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .found     (pick_found)
   );

   assign owner_valid = bus.req_valid_i[owner_idx];
   assign sel_idx     = (state == S_IDLE) ? pick_idx : owner_idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state    = state;
      capture       = 1'b0;
      release_frame = 1'b0;
      done_set      = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      wd_expire     = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (pick_found) begin
               capture    = 1'b1;
               next_state = S_START;
            end
         end
         S_START: next_state = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus.tx_done_i) begin
               done_set = 1'b1;
               if (last_q) begin
                  release_frame = 1'b1;
                  next_state    = S_IDLE;
               end else begin
                  next_state = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // Only the owner may continue; everyone else waits for the frame to end.
            if (owner_valid) begin
               capture    = 1'b1;
               next_state = S_START;
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               wd_expire     = 1'b1;
               release_frame = 1'b1;
               next_state    = S_IDLE;
            end
`endif
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_idx  <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
         grant_q    <= '0;
         tx_data_q  <= '0;
         last_q     <= 1'b0;
         done_q     <= '0;
      end else begin
         done_q <= done_set ? grant_q : '0;
         if (capture) begin
            tx_data_q <= req_bytes[sel_idx];
            last_q    <= bus.req_last_i[sel_idx];
            if (state == S_IDLE) begin
               owner_idx <= pick_idx;
               grant_q   <= pick_grant;
            end
         end
         if (release_frame) begin
            last_owner <= owner_idx;
            grant_q    <= '0;
         end
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_expire;
         if (state == S_HOLD && next_state == S_HOLD) wd_cnt <= wd_cnt + 32'd1;
         else                                         wd_cnt <= '0;
      end
   end

   assign bus.timeout_o = timeout_q;
`else
   assign bus.timeout_o = 1'b0;
`endif

   assign bus.tx_start_o = (state == S_START);
   assign bus.req_ack_o  = (state == S_START) ? grant_q : '0;
   assign bus.grant_o    = grant_q;
   assign bus.tx_data_o  = tx_data_q;
   assign bus.req_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
   import c2_pkg::*;

   localparam int N  = 3;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic inject_done;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

   uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [1:0] req;
      logic [7:0] data;
      logic       last;
   } src_t;

   typedef struct packed {
      logic [7:0]   data;
      logic [N-1:0] grant;
   } exp_t;

   typedef struct {
      int           req;
      logic [7:0]   data;
      logic [N-1:0] exp_grant;
   } vec_t;

   src_t         src_q [$];
   exp_t         exp_q [$];
   logic [N-1:0] done_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int find_src(input int k);
      for (int i = 0; i < src_q.size(); i++)
         if (int'(src_q[i].req) == k) return i;
      return -1;
   endfunction

   task automatic src_push(input int k, input logic [7:0] d, input logic last);
      src_t s;
      s.req  = 2'(k);
      s.data = d;
      s.last = last;
      src_q.push_back(s);
   endtask

   task automatic exp_push(input logic [7:0] d, input logic [N-1:0] g);
      exp_t e;
      e.data  = d;
      e.grant = g;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input string name, input int kind, input int k, output int n);
      logic hit;
      n = 0;
      forever begin
         case (kind)
            0:       hit = bus.req_valid_i[k];
            1:       hit = bus.req_ack_o[k];
            2:       hit = bus.req_done_o[k];
            3:       hit = bus.tx_start_o;
            default: hit = bus.timeout_o;
         endcase
         if (hit || n >= 100) break;
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 300 && !(src_q.size() == 0 && exp_q.size() == 0 && done_q.size() == 0 &&
                          bus.grant_o == '0 && !bus.tx_start_o)) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, 32'(n < 300), 32'd1);
   endtask

   // Requesters: present the head byte of each source, retire it the cycle after its ack.
   logic [N-1:0] ack_seen;
   always @(negedge clk) ack_seen = bus.req_ack_o;

   always @(posedge clk) begin
      int idx;
      #1;
      if (rst) begin
         src_q.delete();
         bus.req_valid_i = '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (ack_seen[k] && bus.req_valid_i[k]) begin
               idx = find_src(k);
               if (idx >= 0) src_q.delete(idx);
               bus.req_valid_i[k] = 1'b0;
            end
            idx = find_src(k);
            if (!bus.req_valid_i[k] && idx >= 0) begin
               bus.req_data_i[8*k +: 8] = src_q[idx].data;
               bus.req_last_i[k]        = src_q[idx].last;
               bus.req_valid_i[k]       = 1'b1;
            end
         end
      end
   end

   // Transceiver: end-of-byte pulse a fixed number of cycles after each start.
   int done_cnt = 0;
   always @(posedge clk) begin
      logic done_now;
      #2;
      if (rst) begin
         done_cnt      = 0;
         bus.tx_done_i = 1'b0;
      end else begin
         done_now = 1'b0;
         if (bus.tx_start_o) done_cnt = 3;
         else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) done_now = 1'b1;
         end
         bus.tx_done_i = done_now | inject_done;
      end
   end

   // Scoreboard: every start pops the next expected byte, every done pops its owner.
   logic prev_done;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (bus.tx_start_o) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_start: data %0h grant %0b, none expected", bus.tx_data_o, bus.grant_o);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", 32'(bus.tx_data_o), 32'(e.data));
               check("grant", 32'(bus.grant_o), 32'(e.grant));
               check("ack", 32'(bus.req_ack_o), 32'(e.grant));
               done_q.push_back(e.grant);
            end
         end else if (bus.req_ack_o != '0) begin
            check("stray_ack", 32'(bus.req_ack_o), 32'd0);
         end
         if (bus.req_done_o != '0) begin
            check("done_follows_tx_done", 32'(prev_done), 32'd1);
            if (done_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_done: req_done %0b, none expected", bus.req_done_o);
            end else begin
               check("req_done", 32'(bus.req_done_o), 32'(done_q.pop_front()));
            end
         end
`ifndef UART_TX_SCHED_TIMEOUT_EN
         if (bus.timeout_o) check("stray_timeout", 32'(bus.timeout_o), 32'd0);
`endif
         prev_done = bus.tx_done_i;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs [6];
      int   n;
      int   seen;

      vecs[0] = '{TX_REQ_ARBITER, 8'h00, 3'b001};
      vecs[1] = '{TX_REQ_DUMPER,  8'hFF, 3'b100};
      vecs[2] = '{TX_REQ_LOADER,  8'h81, 3'b010};
      vecs[3] = '{TX_REQ_LOADER,  8'h7E, 3'b010};
      vecs[4] = '{TX_REQ_ARBITER, 8'hC3, 3'b001};
      vecs[5] = '{TX_REQ_DUMPER,  8'h3C, 3'b100};

      rst             = 1'b1;
      inject_done     = 1'b0;
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.req_last_i  = '0;
      bus.tx_done_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(bus.grant_o), 32'd0);
      check("rst_start", 32'(bus.tx_start_o), 32'd0);
      check("rst_ack", 32'(bus.req_ack_o), 32'd0);
      check("rst_done", 32'(bus.req_done_o), 32'd0);
      check("rst_data", 32'(bus.tx_data_o), 32'd0);
      check("rst_timeout", 32'(bus.timeout_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Loader single byte: start one cycle after valid.
      src_push(TX_REQ_LOADER, 8'h55, 1'b1);
      exp_push(8'h55, 3'b010);
      wait_until("lat_valid", 0, TX_REQ_LOADER, n);
      check("lat_no_start_yet", 32'(bus.tx_start_o), 32'd0);
      @(negedge clk);
      check("lat_start", 32'(bus.tx_start_o), 32'd1);
      check("lat_data", 32'(bus.tx_data_o), 32'h55);
      wait_idle("single");

      for (int i = 0; i < 6; i++) begin
         src_push(vecs[i].req, vecs[i].data, 1'b1);
         exp_push(vecs[i].data, vecs[i].exp_grant);
         wait_idle("vec");
      end

      // Dumper frame locks out the arbiter until its last byte.
      src_push(TX_REQ_DUMPER, 8'hA1, 1'b0);
      src_push(TX_REQ_DUMPER, 8'hA2, 1'b0);
      src_push(TX_REQ_DUMPER, 8'hA3, 1'b1);
      exp_push(8'hA1, 3'b100);
      exp_push(8'hA2, 3'b100);
      exp_push(8'hA3, 3'b100);
      exp_push(8'h0F, 3'b001);
      wait_until("frame_ack", 1, TX_REQ_DUMPER, n);
      src_push(TX_REQ_ARBITER, 8'h0F, 1'b1);
      wait_idle("frame");

      // tx_done while idle must be ignored.
      inject_done = 1'b1;
      @(negedge clk);
      inject_done = 1'b0;
      @(negedge clk);
      check("idle_done_grant", 32'(bus.grant_o), 32'd0);
      check("idle_done_req_done", 32'(bus.req_done_o), 32'd0);

      // tx_done during S_START must be ignored.
      src_push(TX_REQ_LOADER, 8'h96, 1'b1);
      exp_push(8'h96, 3'b010);
      wait_until("start_done_valid", 0, TX_REQ_LOADER, n);
      inject_done = 1'b1;
      @(negedge clk);
      inject_done = 1'b0;
      @(negedge clk);
      check("start_done_ignored", 32'(bus.req_done_o), 32'd0);
      wait_idle("start_done");

      // Asynchronous reset in the middle of a 4-byte frame.
      src_push(TX_REQ_LOADER, 8'hB0, 1'b0);
      src_push(TX_REQ_LOADER, 8'hB1, 1'b0);
      src_push(TX_REQ_LOADER, 8'hB2, 1'b0);
      src_push(TX_REQ_LOADER, 8'hB3, 1'b1);
      exp_push(8'hB0, 3'b010);
      wait_until("mid_start", 3, 0, n);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_grant", 32'(bus.grant_o), 32'd0);
      check("mid_rst_data", 32'(bus.tx_data_o), 32'd0);
      check("mid_rst_start", 32'(bus.tx_start_o), 32'd0);
      check("mid_rst_ack", 32'(bus.req_ack_o), 32'd0);
      check("mid_rst_done", 32'(bus.req_done_o), 32'd0);
      exp_q.delete();
      done_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_idle", 32'(bus.grant_o), 32'd0);

      // Three-way tie after reset: 0, 1, 2, then requester 0 again.
      src_push(TX_REQ_ARBITER, 8'hC0, 1'b1);
      src_push(TX_REQ_LOADER,  8'hC1, 1'b1);
      src_push(TX_REQ_DUMPER,  8'hC2, 1'b1);
      src_push(TX_REQ_ARBITER, 8'hC3, 1'b1);
      exp_push(8'hC0, 3'b001);
      exp_push(8'hC1, 3'b010);
      exp_push(8'hC2, 3'b100);
      exp_push(8'hC3, 3'b001);
      wait_idle("tie");

      // Owner stalls mid-frame while the loader waits.
      src_push(TX_REQ_DUMPER, 8'hD0, 1'b0);
      exp_push(8'hD0, 3'b100);
      wait_until("stall_ack", 1, TX_REQ_DUMPER, n);
      src_push(TX_REQ_LOADER, 8'h5A, 1'b1);
      wait_until("stall_done", 2, TX_REQ_DUMPER, n);
`ifdef UART_TX_SCHED_TIMEOUT_EN
      exp_push(8'h5A, 3'b010);
      wait_until("stall_timeout", 4, 0, n);
      check("timeout_delay", 32'(n), 32'd16);
      check("timeout_grant", 32'(bus.grant_o), 32'd0);
      wait_idle("timeout");
`else
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.timeout_o) seen++;
      end
      check("hold_no_timeout", 32'(seen), 32'd0);
      check("hold_grant", 32'(bus.grant_o), 32'b100);
      check("hold_loader_waiting", 32'(bus.req_valid_i[TX_REQ_LOADER]), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Frame-locking, round-robin scheduler that shares the single UART transmitter among the C2 subsystem's byte sources: the arbiter's command echo, the loader acknowledgments and the dumping unit stream. Each requester owns the transmitter for a whole frame, so multi-byte dumps are never interleaved with other traffic. The block sits between the requesters and the `uart_transceiver` TX port and replaces the ad-hoc TX mux inside the arbiter.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, ≥2; index 0 = arbiter, 1 = loader, 2 = dumper.
- `TIMEOUT_CYCLES`, 1_000_000: hold-state watchdog limit. Used only when the watchdog is compiled in.

Ports:
- `clk_i` in 1: single system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in NUM_REQ: requester has a byte; held until its `req_ack_o`.
- `req_data_i` in NUM_REQ×8: byte of requester k at bits [8k+7:8k].
- `req_last_i` in NUM_REQ: the byte is the final byte of its frame; sampled together with the data.
- `req_ack_o` out NUM_REQ: one-cycle pulse, byte captured.
- `req_done_o` out NUM_REQ: one-cycle pulse, that requester's byte has finished serializing.
- `grant_o` out NUM_REQ: one-hot current frame owner; all zero when idle.
- `tx_data_o` out 8: byte to the transceiver; registered.
- `tx_start_o` out 1: one-cycle start pulse to the transceiver.
- `tx_done_i` in 1: transceiver end-of-byte pulse.
- `timeout_o` out 1: one-cycle pulse when a frame lock is force-released.

## Operation
The state machine has four states.
- **S_IDLE**
  - The block checks `req_valid_i` and picks a winner round-robin, searching upward from `last_owner+1` modulo NUM_REQ.
  - It latches the winner's data and last flag, sets `grant_o`, and moves to S_START.
- **S_START**
  - Drives `tx_start_o`=1 and `req_ack_o[owner]`=1 for exactly one cycle.
  - Then moves to S_WAIT_DONE.
- **S_WAIT_DONE**
  - Waits for `tx_done_i` and pulses `req_done_o[owner]` on the next cycle.
  - If the latched byte was the last: set `last_owner` = owner, clear `grant_o`, go to S_IDLE.
  - Otherwise go to S_HOLD.
- **S_HOLD**
  - The frame stays locked and only the owner's `req_valid_i` is examined.
  - When it is set: latch the byte and last flag, then go to S_START.

Rules:
- `req_valid_i` from non-owners is ignored while any frame is locked.
- `tx_done_i` is ignored outside S_WAIT_DONE.
- A requester must hold data and last stable from asserting valid until the ack cycle. It may drop or replace valid in the cycle after the ack.
- `last_owner` is $clog2(NUM_REQ) bits and resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values: all outputs 0; state S_IDLE; `last_owner` = NUM_REQ-1; watchdog counter 0.
- Reset mid-frame aborts the frame immediately. No `req_done_o` is generated.
- Valid in cycle N (S_IDLE or S_HOLD) → `tx_start_o` and `req_ack_o` in N+1, with `tx_data_o` already stable in N+1.
- `tx_done_i` in cycle M → `req_done_o` in M+1.
  - The next start comes at the earliest in M+2, when the owner's valid is already set in M+1.
- `tx_data_o` holds its value until the next capture.
- Simultaneous requests in S_IDLE: the round-robin winner is taken. Losers keep valid set and are served in rotation order after the current frame ends.
- A single-byte frame (`req_last_i`=1 on the first byte) returns to S_IDLE with no S_HOLD visit.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined:
  - A 32-bit counter runs while in S_HOLD and clears on leaving it.
  - When it reaches TIMEOUT_CYCLES-1 with no owner valid, the block pulses `timeout_o`, sets `last_owner` = owner, clears `grant_o` and goes to S_IDLE.
- Not defined:
  - No counter is built, `timeout_o` is tied to 0, and S_HOLD waits indefinitely.

## Structure
- `c2_pkg` holds:
  - `tx_sched_state_e` (S_IDLE, S_START, S_WAIT_DONE, S_HOLD);
  - the requester index constants `TX_REQ_ARBITER`=0, `TX_REQ_LOADER`=1, `TX_REQ_DUMPER`=2.
- One sub-module, `rr_priority_picker`, is natural: a combinational rotate-and-find-first over the request vector, outputting a one-hot grant and an index.

## Test plan
- Loader sends single byte 0x55 with last=1 → `tx_start_o` one cycle after valid; `tx_data_o`=0x55; after `tx_done_i`, `req_done_o[1]` pulses and `grant_o` returns to 0.
- Dumper sends frame 0xA1,0xA2,0xA3 (last on 0xA3) while the arbiter raises valid with 0x0F after 0xA1 → UART order A1,A2,A3,0F; `grant_o` stays 3'b100 until A3 is done.
- All three requesters valid from reset, single-byte frames → service order 0,1,2,0; each `req_ack_o` pulses exactly once per byte.
- `tx_done_i` pulsed while in S_IDLE and during S_START → no state change and no `req_done_o`.
- `rst_i` asserted during S_WAIT_DONE of a 4-byte frame → all outputs 0 in the same cycle; afterwards requester 0 wins a three-way tie.
- With `UART_TX_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the owner drops valid mid-frame → `timeout_o` pulses 16 cycles after entering S_HOLD, then the pending loader byte is served.
